aes128_key_expansion_fwd: RTL and testbench

//  Forward AES-128 key schedule: accepts a 128-bit cipher key and emits round keys 0..10 in

---
 rtl/aes128_pkg.sv | 66 ++++++
 rtl/aes128_key_round_fwd.sv | 42 ++++
 rtl/aes128_key_expansion_fwd.sv | 88 ++++++++
 tb/tb_aes128_key_expansion_fwd.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// AES-128 shared types, constants and GF(2^8) helpers.
// aes128_sbox is the single S-box used by forward and inverse paths.
package aes128_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE,
    OUT
  } kexp_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes128_sbox(
    input logic [7:0] x,
    input logic       inv
  );
    logic [7:0] a;
    if (inv) begin
      a = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      return gf_inv(a);
    end
    a = gf_inv(x);
    return a ^ rotl8(a, 1) ^ rotl8(a, 2)
             ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes128_key_round_fwd.sv
// One combinational forward AES-128 key schedule step.
// Maps the current round key and rcon to the next round key.
module aes128_key_round_fwd
  import aes128_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_next_key
);

  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  assign w_sub = {
    aes128_sbox(w_rot[31:24], 1'b0),
    aes128_sbox(w_rot[23:16], 1'b0),
    aes128_sbox(w_rot[15:8],  1'b0),
    aes128_sbox(w_rot[7:0],   1'b0)
  };

  assign w_t  = w_sub ^ {i_rcon, 24'h0};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_key_expansion_fwd.sv
// Forward AES-128 key schedule streaming round keys 0..10.
// Captures round key 10 for the decipher key schedule.
module aes128_key_expansion_fwd
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] cipher_key,
  output logic         rkey_valid,
  input  logic         rkey_ready,
  output logic [127:0] rkey_data,
  output logic [3:0]   rkey_num,
  output logic [127:0] round_key_10,
  output logic         key10_valid,
  output logic         busy
);

  generate
    if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
      $error("aes128_key_expansion_fwd: NUM_ROUNDS must be 10");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  kexp_state_t  r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_num;
  logic [127:0] r_rk10;
  logic         r_k10v;
  logic [127:0] w_next;

  aes128_key_round_fwd u_round (
    .i_key      (r_key),
    .i_rcon     (r_rcon),
    .o_next_key (w_next)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_rcon  <= RCON_INIT;
      r_num   <= '0;
      r_rk10  <= '0;
      r_k10v  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_key   <= cipher_key;
            r_num   <= '0;
            r_rcon  <= RCON_INIT;
            r_k10v  <= 1'b0;
            r_state <= OUT;
          end
        end
        OUT: begin
          if (rkey_ready) begin
            if (r_num == LAST) begin
              r_rk10  <= r_key;
              r_k10v  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_key  <= w_next;
              r_num  <= r_num + 4'd1;
              r_rcon <= xtime(r_rcon);
            end
          end
        end
      endcase
    end
  end

  assign key_ready    = (r_state == IDLE);
  assign rkey_valid   = (r_state == OUT);
  assign busy         = (r_state == OUT);
  assign rkey_data    = r_key;
  assign rkey_num     = r_num;
  assign round_key_10 = r_rk10;
  assign key10_valid  = r_k10v;

endmodule

// File: tb/tb_aes128_key_expansion_fwd.sv
// Scoreboard bench for aes128_key_expansion_fwd.
// Reference: FIPS-197 word recurrence with a generator-built S-box.
module tb_aes128_key_expansion_fwd;

  logic         clk_sys = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] cipher_key = '0;
  logic         rkey_valid;
  logic         rkey_ready = 1'b0;
  logic [127:0] rkey_data;
  logic [3:0]   rkey_num;
  logic [127:0] round_key_10;
  logic         key10_valid;
  logic         busy;

  always #5 clk_sys = ~clk_sys;

  aes128_key_expansion_fwd dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .cipher_key   (cipher_key),
    .rkey_valid   (rkey_valid),
    .rkey_ready   (rkey_ready),
    .rkey_data    (rkey_data),
    .rkey_num     (rkey_num),
    .round_key_10 (round_key_10),
    .key10_valid  (key10_valid),
    .busy         (busy)
  );

  typedef struct packed {
    logic [3:0]   num;
    logic [127:0] data;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   bp_mode = 1'b0;
  exp_t sbq[$];

  logic [7:0]   sb[256];
  logic [7:0]   rc[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] mk[11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string name, input logic [131:0] act,
                     input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // S-box from the multiply-by-3 / divide-by-3 generator walk
  function automatic void build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w[44];
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0)
        w[i] = w[i-4] ^ subw(rotw(w[i-1])) ^ {rc[i/4-1], 24'h0};
      else
        w[i] = w[i-4] ^ w[i-1];
    end
    for (int r = 0; r < 11; r++)
      mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] rk,
                                            input int r);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3;
    {w0, w1, w2, w3} = rk;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ subw(rotw(p3)) ^ {rc[r-1], 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      rkey_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected round key per accepted transfer
  initial begin
    bit           stall = 1'b0;
    bit           pend10 = 1'b0;
    logic [131:0] stall_val = '0;
    logic [127:0] rk10_exp = '0;
    exp_t         e;
    forever begin
      @(negedge clk_sys);
      if (rst) begin
        stall  = 1'b0;
        pend10 = 1'b0;
      end else begin
        if (pend10) begin
          chk("rk10_value", 132'(round_key_10), 132'(rk10_exp));
          chk("rk10_valid", 132'(key10_valid), 132'(1'b1));
          chk("idle_after_10", 132'(key_ready), 132'(1'b1));
          pend10 = 1'b0;
        end
        if (stall && rkey_valid)
          chk("stall_hold", {rkey_num, rkey_data}, stall_val);
        stall     = rkey_valid && !rkey_ready;
        stall_val = {rkey_num, rkey_data};
        if (rkey_valid && rkey_ready) begin
          chk("k10v_low_in_out", 132'(key10_valid), 132'(1'b0));
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rkey actual=%0d required=none", rkey_num);
          end else begin
            e = sbq.pop_front();
            chk("rkey_num", 132'(rkey_num), 132'(e.num));
            chk("rkey_data", 132'(rkey_data), 132'(e.data));
            if (e.num == 4'd10) begin
              pend10   = 1'b1;
              rk10_exp = e.data;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [127:0] k);
    expand(k);
    for (int r = 0; r < 11; r++) sbq.push_back({4'(r), mk[r]});
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk_sys);
    while (!key_ready && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready actual=0 required=1");
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    wait_ready();
    key_valid  = 1'b1;
    cipher_key = k;
    @(posedge clk_sys);
    #1;
    push_exp(k);
    key_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk_sys);
    while ((sbq.size() != 0 || !key_ready) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("drain", 132'(sbq.size()), 132'(0));
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    int           n;
    logic         kr;
    logic [127:0] ka, kb, r;
    build_sbox();

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_rkey_valid", 132'(rkey_valid), 132'(1'b0));
    chk("rst_key_ready", 132'(key_ready), 132'(1'b1));
    chk("rst_busy", 132'(busy), 132'(1'b0));
    chk("rst_k10v", 132'(key10_valid), 132'(1'b0));
    chk("rst_num", 132'(rkey_num), 132'(0));
    chk("rst_data", 132'(rkey_data), 132'(0));
    chk("rst_rk10", 132'(round_key_10), 132'(0));
    @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // FIPS-197 A.1 with exact latency
    send_key(FIPS_KEY);
    after_edges(1);
    chk("fips_r1", {rkey_num, rkey_data}, {4'd1, FIPS_R1});
    after_edges(9);
    chk("fips_r10", {rkey_num, rkey_data}, {4'd10, FIPS_R10});
    chk("k10v_at_n10", 132'(key10_valid), 132'(1'b0));
    after_edges(1);
    chk("k10v_at_n11", 132'(key10_valid), 132'(1'b1));
    chk("ready_at_n11", 132'(key_ready), 132'(1'b1));
    chk("fips_rk10", 132'(round_key_10), 132'(FIPS_R10));

    // random backpressure
    bp_mode = 1'b1;
    send_key(FIPS_KEY);
    wait_done();
    bp_mode = 1'b0;

    // reset during round 5
    send_key(rnd_key());
    n = 0;
    @(negedge clk_sys);
    while (rkey_num != 4'd5 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("reach_num5", 132'(rkey_num), 132'(5));
    @(posedge clk_sys);
    #1;
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk_sys);
    chk("mid_rst_rkey_valid", 132'(rkey_valid), 132'(1'b0));
    chk("mid_rst_k10v", 132'(key10_valid), 132'(1'b0));
    chk("mid_rst_key_ready", 132'(key_ready), 132'(1'b1));
    send_key(rnd_key());
    wait_done();

    // key_valid held through OUT with a second key
    ka = rnd_key();
    kb = rnd_key();
    wait_ready();
    key_valid  = 1'b1;
    cipher_key = ka;
    @(posedge clk_sys);
    #1;
    push_exp(ka);
    cipher_key = kb;
    n = 0;
    kr = 1'b0;
    while (!kr && n < 100) begin
      @(negedge clk_sys);
      kr = key_ready;
      @(posedge clk_sys);
      n++;
    end
    #1;
    push_exp(kb);
    key_valid = 1'b0;
    chk("second_accept_gap", 132'(n), 132'(12));
    wait_done();

    // back-to-back zero then all-ones
    send_key('0);
    wait_done();
    chk("zero_rk10", 132'(round_key_10), 132'(ZERO_R10));
    send_key('1);
    @(negedge clk_sys);
    chk("k10v_cleared", 132'(key10_valid), 132'(1'b0));
    wait_done();

    // inverse schedule from captured round key 10
    bp_mode = 1'b1;
    send_key(rnd_key());
    wait_done();
    r = round_key_10;
    for (int rr = 10; rr >= 1; rr--) begin
      r = inv_step(r, rr);
      chk("inv_sched", 132'(r), 132'(mk[rr-1]));
    end

    for (int i = 0; i < 6; i++) begin
      send_key(rnd_key());
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
